// File: rtl/iterative_compare_unit.sv
// Multi-cycle signed/unsigned magnitude and equality comparator.
// It scans the operands one chunk per cycle, starting at the MSB chunk, and stops at the first chunk that differs.
module iterative_compare_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            result,
  output logic            lt,
  output logic            eq,
  output logic            illegal
);

  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                        state_q;
  logic [XLEN-1:0]               a_q, b_q;
  logic [2:0]                    op_q;
  logic [IdxW-1:0]               idx_q;
  logic                          ill_q;

  logic [NCHUNK-1:0][CHUNK-1:0]  a_chunks, b_chunks;
  logic [CHUNK-1:0]              chunk_a, chunk_b;
  logic                          is_signed;
  logic                          chunk_lt, chunk_eq;

  assign a_chunks  = a_q;
  assign b_chunks  = b_q;
  assign is_signed = (op_q[2:1] == 2'b10);

  // Flipping the sign bit on the top chunk turns a signed compare into an unsigned one.
  always_comb begin
    chunk_a = a_chunks[idx_q];
    chunk_b = b_chunks[idx_q];
    if (is_signed && (idx_q == LastIdx)) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
    chunk_lt = (chunk_a < chunk_b);
    chunk_eq = (chunk_a == chunk_b);
  end

  function automatic logic map_result(input logic [2:0] o, input logic l, input logic e);
    logic r;
    r = 1'b0;
    case (o)
      3'b000:         r = e;
      3'b001:         r = ~e;
      3'b100, 3'b110: r = l;
      3'b101, 3'b111: r = ~l;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      illegal   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      ill_q     <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            idx_q    <= LastIdx;
            ill_q    <= (op[2:1] == 2'b01);
            in_ready <= 1'b0;
            state_q  <= StScan;
          end
        end
        StScan: begin
          // An illegal op resolves on its first scan cycle, so it also completes one edge after accept.
          if (ill_q) begin
            illegal   <= 1'b1;
            result    <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (!chunk_eq) begin
            illegal   <= 1'b0;
            lt        <= chunk_lt;
            eq        <= 1'b0;
            result    <= map_result(op_q, chunk_lt, 1'b0);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (idx_q == '0) begin
            illegal   <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b1;
            result    <= map_result(op_q, 1'b0, 1'b1);
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_compare_unit.sv
// Scoreboard bench for iterative_compare_unit with directed vectors and hand-computed expectations.
module tb_iterative_compare_unit;

  localparam logic [2:0] OpEq  = 3'b000;
  localparam logic [2:0] OpNe  = 3'b001;
  localparam logic [2:0] OpLt  = 3'b100;
  localparam logic [2:0] OpGe  = 3'b101;
  localparam logic [2:0] OpLtu = 3'b110;
  localparam logic [2:0] OpGeu = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        result, lt, eq, illegal;

  typedef struct {
    logic res;
    logic lt;
    logic eq;
    logic ill;
    int   lat;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  bit   seen = 1'b0;

  iterative_compare_unit #(.XLEN(64), .CHUNK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .lt        (lt),
    .eq        (eq),
    .illegal   (illegal)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got out_valid=1 expected no output (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("result",  result,  e.res);
          check("lt",      lt,      e.lt);
          check("eq",      eq,      e.eq);
          check("illegal", illegal, e.ill);
          check("latency", first_cyc - e.acc, e.lat);
        end
        seen = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic accept_only(input logic [63:0] ai, input logic [63:0] bi, input logic [2:0] opi);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    a        = ai;
    b        = bi;
    op       = opi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands after the accept edge must not matter.
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    op       = 3'($urandom);
  endtask

  task automatic issue(input logic [63:0] ai, input logic [63:0] bi, input logic [2:0] opi,
                       input logic er, input logic el, input logic ee, input logic ei,
                       input int lat);
    exp_t e;
    accept_only(ai, bi, opi);
    e.res = er;
    e.lt  = el;
    e.eq  = ee;
    e.ill = ei;
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result",    result,    0);
    check("rst_lt",        lt,        0);
    check("rst_eq",        eq,        0);
    check("rst_illegal",   illegal,   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("rel_in_ready_after_edge", in_ready, 1);

    issue(64'd5, 64'd7, OpLtu, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OpLt,  1'b1, 1'b1, 1'b0, 1'b0, 1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OpLtu, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, OpEq, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    issue(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, OpNe, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    issue(64'h8000_0000_0000_0000, 64'd0, OpGe,  1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(64'h8000_0000_0000_0000, 64'd0, OpGeu, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(64'h0000_0000_0001_0000, 64'd0, OpEq,  1'b0, 1'b0, 1'b0, 1'b0, 3);
    issue(64'd3, 64'h0000_0123_0000_0000, OpGeu, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    issue(64'd9, 64'd9, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(64'd1, 64'd2, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    wait_drain();

    // Backpressure: three stalled cycles, release on the fourth.
    out_ready = 1'b0;
    issue(64'd5, 64'd7, OpLt, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_result",    result,    1);
      check("bp_lt",        lt,        1);
      check("bp_eq",        eq,        0);
      check("bp_in_ready",  in_ready,  0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);
    wait_drain();

    // Async reset in the middle of a scan.
    accept_only(64'd5, 64'd7, OpLtu);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_scan_out_valid", out_valid, 0);
    check("rst_scan_in_ready",  in_ready,  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(64'd100, 64'd7, OpGeu, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    wait_drain();

    // Async reset while a result is held in DONE.
    out_ready = 1'b0;
    accept_only(64'd0, 64'd0, 3'b010);
    @(posedge clk);
    #1;
    check("pre_rst_done_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_illegal",   illegal,   0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Flush mid-scan discards the op.
    accept_only(64'd5, 64'd7, OpLtu);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_in_ready",  in_ready,  1);
    check("flush_out_valid", out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    check("flush_no_output", out_valid, 0);
    issue(64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000, OpLt, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
